// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the RISC-V fetch path.
//               - NOP encoding used for fetch-fault entries
//               - RUN/HALT fetch state encoding
//               - Default reset PC
//               - Queue entry layout {pc, inst, fault} (65 bits)
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam logic [31:0] C_NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bus bundle between the fetch unit, the instruction memory,
//               the redirect source and decode.
//   master (fetch unit): drives imem_addr, inst_valid, inst_out, inst_pc,
//                        inst_fault, q_count; samples imem_rd,
//                        redirect_valid, redirect_pc, inst_ready.
//   slave  (environment): the opposite directions.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   imem_addr;
  logic [31:0]   imem_rd;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_out;
  logic [31:0]   inst_pc;
  logic          inst_fault;
  logic [CW-1:0] q_count;

  modport master (
    output imem_addr,
    input  imem_rd,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_out,
    output inst_pc,
    output inst_fault,
    output q_count
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_out,
    input  inst_pc,
    input  inst_fault,
    input  q_count
  );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : DEPTH-entry in-order synchronous FIFO of fetch entries.
//               Supports push and pop in the same cycle while full, and a
//               synchronous flush that empties the queue (flush wins over
//               push and pop).
//   clk, reset   : clock, synchronous active-high reset
//   i_flush      : discard all entries
//   i_push       : write i_push_data
//   i_push_data  : {pc, inst, fault}
//   i_pop        : retire head (ignored when empty)
//   o_count      : occupancy
//   o_head       : head entry (all zero when empty)
//   o_valid      : head valid
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          i_flush,
  input  wire logic          i_push,
  input  wire fetch_entry_t  i_push_data,
  input  wire logic          i_pop,
  output logic [CW-1:0]      o_count,
  output fetch_entry_t       o_head,
  output logic               o_valid
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = i_pop & (r_count != '0);
  // A full queue still accepts a push when the head leaves this cycle.
  assign w_push = i_push & ((r_count < CW'(DEPTH)) | w_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (w_push && !reset && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch sequencer. Owns the fetch PC, reads the
//               word-addressed instruction memory, and queues
//               {pc, inst, fault} for decode. Redirects flush the queue;
//               a misaligned or out-of-range PC produces one fault entry
//               (NOP, fault=1) and halts fetch until a redirect or reset.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : fetch_unit_if.master (imem, redirect, decode handshake, q_count)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = C_DEFAULT_RESET_PC,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = 32
) (
  input  wire logic     clk,
  input  wire logic     reset,
  fetch_unit_if.master  bus
);

  localparam int          CW         = $clog2(DEPTH) + 1;
  localparam logic [31:0] C_PC_LIMIT = 32'(IMEM_WORDS * 4);

  logic [31:0]   r_fetch_pc;
  fetch_state_e  r_state;

  logic          w_pop;
  logic          w_can_enq;
  logic          w_legal;
  logic          w_push;
  logic [CW-1:0] w_count;
  logic          w_valid;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

  assign w_pop     = w_valid & bus.inst_ready;
  assign w_can_enq = (r_state == ST_RUN) & ((w_count < CW'(DEPTH)) | w_pop);
  assign w_legal   = (r_fetch_pc[1:0] == 2'b00) & (r_fetch_pc < C_PC_LIMIT);
  // Anything enqueued in a redirect cycle belongs to the old path.
  assign w_push    = w_can_enq & ~bus.redirect_valid;

  assign w_push_data.pc    = r_fetch_pc;
  assign w_push_data.inst  = w_legal ? bus.imem_rd : C_NOP_INST;
  assign w_push_data.fault = ~w_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_state    <= ST_RUN;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= bus.redirect_pc;
      r_state    <= ST_RUN;
    end else if (w_can_enq) begin
      if (w_legal) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end else begin
        // PC held so imem_addr keeps pointing at the faulting address.
        r_state <= ST_HALT;
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (bus.redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head),
    .o_valid     (w_valid)
  );

  assign bus.imem_addr  = r_fetch_pc;
  assign bus.inst_valid = w_valid;
  assign bus.inst_out   = w_head.inst;
  assign bus.inst_pc    = w_head.pc;
  assign bus.inst_fault = w_head.fault;
  assign bus.q_count    = w_count;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] mem [32];

  fetch_unit_if #(.DEPTH(2)) bus ();

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .DEPTH      (2),
    .IMEM_WORDS (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.imem_rd = mem[bus.imem_addr[6:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc,
                          input logic [31:0] inst, input logic fault);
    chk({tag, ".valid"}, {31'd0, bus.inst_valid}, 32'd1);
    chk({tag, ".pc"},    bus.inst_pc, pc);
    chk({tag, ".inst"},  bus.inst_out, inst);
    chk({tag, ".fault"}, {31'd0, bus.inst_fault}, {31'd0, fault});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = 32'h0010_0093;
    mem[1]  = 32'h0020_0113;
    mem[2]  = 32'h0020_81B3;
    mem[14] = 32'h0261_8063;
    mem[31] = 32'hCAFE_F00D;

    reset              = 1'b1;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Reset values
    step();
    step();
    chk("rst.valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst.imem_addr", bus.imem_addr, 32'h0);
    chk("rst.q_count", {30'd0, bus.q_count}, 32'd0);
    chk("rst.inst_out", bus.inst_out, 32'h0);
    chk("rst.inst_pc", bus.inst_pc, 32'h0);
    chk("rst.fault", {31'd0, bus.inst_fault}, 32'd0);

    // Streaming with ready held high: one instruction per cycle
    reset          = 1'b0;
    bus.inst_ready = 1'b1;
    step();
    chk_head("s0", 32'h0, 32'h0010_0093, 1'b0);
    chk("s0.imem_addr", bus.imem_addr, 32'h4);
    step();
    chk_head("s1", 32'h4, 32'h0020_0113, 1'b0);
    step();
    chk_head("s2", 32'h8, 32'h0020_81B3, 1'b0);

    // Back-pressure from a fresh reset
    reset = 1'b1;
    step();
    chk("bp.rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    reset          = 1'b0;
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp.q_count", {30'd0, bus.q_count}, 32'd2);
    chk("bp.imem_addr", bus.imem_addr, 32'h8);
    chk_head("bp.head", 32'h0, 32'h0010_0093, 1'b0);
    bus.inst_ready = 1'b1;
    step();
    chk_head("bp.r1", 32'h4, 32'h0020_0113, 1'b0);
    step();
    chk_head("bp.r2", 32'h8, 32'h0020_81B3, 1'b0);
    step();
    chk_head("bp.r3", 32'hC, 32'h1000_0003, 1'b0);

    // Fill the queue, then redirect to 0x38 with ready high
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("rd.full", {30'd0, bus.q_count}, 32'd2);
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h38;
    step();
    bus.redirect_valid = 1'b0;
    chk("rd.bubble_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rd.bubble_count", {30'd0, bus.q_count}, 32'd0);
    chk("rd.imem_addr", bus.imem_addr, 32'h38);
    step();
    chk_head("rd.t0", 32'h38, 32'h0261_8063, 1'b0);
    step();
    chk_head("rd.t1", 32'h3C, 32'h1000_000F, 1'b0);

    // Run off the end of memory
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h7C;
    step();
    bus.redirect_valid = 1'b0;
    chk("end.bubble", {31'd0, bus.inst_valid}, 32'd0);
    step();
    chk_head("end.last", 32'h7C, 32'hCAFE_F00D, 1'b0);
    step();
    chk_head("end.fault", 32'h80, 32'h0000_0013, 1'b1);
    step();
    chk("end.halt_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("end.halt_addr", bus.imem_addr, 32'h80);
    for (int i = 0; i < 4; i++) step();
    chk("end.halt_valid2", {31'd0, bus.inst_valid}, 32'd0);
    chk("end.halt_addr2", bus.imem_addr, 32'h80);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    step();
    bus.redirect_valid = 1'b0;
    chk("end.resume_bubble", {31'd0, bus.inst_valid}, 32'd0);
    step();
    chk_head("end.resume", 32'h0, 32'h0010_0093, 1'b0);

    // Misaligned redirect target
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h6;
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk_head("mis.fault", 32'h6, 32'h0000_0013, 1'b1);
    step();
    chk("mis.halt_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("mis.halt_addr", bus.imem_addr, 32'h6);
    step();
    chk("mis.halt_valid2", {31'd0, bus.inst_valid}, 32'd0);

    // Reset together with a redirect while the queue is full
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h10;
    step();
    bus.redirect_valid = 1'b0;
    step();
    step();
    chk("rr.full", {30'd0, bus.q_count}, 32'd2);
    chk("rr.head_pc", bus.inst_pc, 32'h10);
    reset              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    step();
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    chk("rr.valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rr.imem_addr", bus.imem_addr, 32'h0);
    chk("rr.q_count", {30'd0, bus.q_count}, 32'd0);
    step();
    chk_head("rr.r0", 32'h0, 32'h0010_0093, 1'b0);
    step();
    chk_head("rr.r1", 32'h4, 32'h0020_0113, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
